inv_cipher_iter: RTL

INV_CIPHER_ITER -- requirements
Module: inv_cipher_iter

---
 rtl/inv_cipher_iter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, a single block in flight.
// Round keys are fetched from an external store addressed by rk_addr.
module inv_cipher_iter #(
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NR = Nk + 6;
  localparam logic [3:0] NR_L = 4'(NR);

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] out_data_reg, out_data_next;
  logic [127:0] ark;
  logic [127:0] imc;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows folded into the S-box input selection: out[r][c] = in[r][c-r].
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = R + 4 * ((C - R + 4) % 4);
    assign ark[127-8*gi -: 8] = inv_sbox(state_reg[127-8*SRC -: 8]) ^ rk_data[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg      <= IDLE;
      cnt_reg      <= '0;
      state_reg    <= '0;
      out_data_reg <= '0;
    end else begin
      fsm_reg      <= fsm_next;
      cnt_reg      <= cnt_next;
      state_reg    <= state_next;
      out_data_reg <= out_data_next;
    end
  end

  always_comb begin
    fsm_next      = fsm_reg;
    cnt_next      = cnt_reg;
    state_next    = state_reg;
    out_data_next = out_data_reg;
    in_ready      = 1'b0;
    rk_addr       = NR_L;

    case (fsm_reg)
      IDLE: in_ready = 1'b1;
      ROUND: begin
        rk_addr    = cnt_reg;
        state_next = imc;
        cnt_next   = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) fsm_next = FINAL;
      end
      FINAL: begin
        rk_addr       = 4'd0;
        out_data_next = ark;
        fsm_next      = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase

    if (rst) in_ready = 1'b0;

    // Acceptance overrides DONE->IDLE so a waiting block starts with no bubble.
    if (in_valid && in_ready) begin
      state_next = in_data ^ rk_data;
      cnt_next   = NR_L - 4'd1;
      fsm_next   = ROUND;
    end
  end

  assign out_valid = (fsm_reg == DONE);
  assign busy      = (fsm_reg == ROUND) || (fsm_reg == FINAL);
  assign out_data  = out_data_reg;

endmodule
